// File: rtl/riscv_pkg.sv
// riscv_pkg: shared op codes, instruction encodings and the issue-entry layout.
package riscv_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LI, OP_RSV} op_e;
  localparam logic [6:0] OPC_ADD = 7'h03;
  localparam logic [6:0] OPC_SUB = 7'h0B;
  localparam logic [6:0] OPC_LI = 7'h37;
  localparam logic [6:0] SUB_FUNCT7 = 7'h20;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] word;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic uses_src;
  } instr_fields;
  // Reserved ops become a NOP with rd=0 so they never block later readers.
  function automatic instr_fields encode(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [11:0] imm);
    instr_fields f;
    f.rd = op == OP_RSV ? 5'd0 : rd;
    f.rs1 = rs1;
    f.rs2 = rs2;
    f.uses_src = op == OP_ADD || op == OP_SUB;
    f.word = op == OP_ADD ? {7'h00, rs2, rs1, 3'h0, rd, OPC_ADD} :
             op == OP_SUB ? {SUB_FUNCT7, rs2, rs1, 3'h0, rd, OPC_SUB} :
             op == OP_LI  ? {imm, 5'd0, 3'h0, rd, OPC_LI} : NOP_WORD;
    return f;
  endfunction
endpackage

// File: rtl/riscv_issue_fifo.sv
// riscv_issue_fifo: synchronous FIFO with occupancy count and flush (flush beats push/pop).
module riscv_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign rdata = mem[rptr];
  always_ff @(posedge i_clk)
    if (do_push) mem[wptr] <= wdata;
  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/riscv_instr_issuer.sv
// riscv_instr_issuer: encodes commands, queues them and issues one word per clock,
// inserting NOPs on an empty queue or a pending read-after-write hazard.
module riscv_instr_issuer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HAZARD_GAP = 2
) (
  input  logic                   i_clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [4:0]             i_cmd_rd,
  input  logic [4:0]             i_cmd_rs1,
  input  logic [4:0]             i_cmd_rs2,
  input  logic [11:0]            i_cmd_imm,
  input  logic                   i_flush,
  output logic [31:0]            o_instr,
  output logic [31:0]            o_pc,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_bubble
);
  instr_fields in_f, head;
  logic full, empty, hazard, issue, started;
  logic [HAZARD_GAP-1:0][4:0] sb;
  assign in_f = encode(op_e'(i_cmd_op), i_cmd_rd, i_cmd_rs1, i_cmd_rs2, i_cmd_imm);
  assign o_cmd_ready = !full;
  assign issue = !empty && !hazard && !i_flush;
  riscv_issue_fifo #(.WIDTH($bits(instr_fields)), .DEPTH(DEPTH)) u_fifo (
    .i_clk(i_clk),
    .rst_n(rst_n),
    .flush(i_flush),
    .push(i_cmd_valid),
    .pop(issue),
    .wdata(in_f),
    .rdata(head),
    .count(o_fifo_count),
    .full(full),
    .empty(empty)
  );
  // A zero slot never matches, so x0 sources and NOP slots are ignored.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_GAP; i++)
      hazard = hazard | (head.uses_src && sb[i] != '0 && (sb[i] == head.rs1 || sb[i] == head.rs2));
  end
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      o_instr <= NOP_WORD;
      o_bubble <= 1'b1;
      o_pc <= '0;
      started <= 1'b0;
      sb <= '0;
    end else begin
      o_instr <= issue ? head.word : NOP_WORD;
      o_bubble <= !issue;
      o_pc <= started ? o_pc + 32'd4 : o_pc;
      started <= 1'b1;
      for (int i = HAZARD_GAP - 1; i > 0; i--)
        sb[i] <= i_flush ? 5'd0 : sb[i-1];
      sb[0] <= issue ? head.rd : 5'd0;
    end
endmodule

// File: tb/tb_riscv_instr_issuer.sv
// tb_riscv_instr_issuer: directed bench with an expected-word queue for the issuer.
module tb_riscv_instr_issuer;
  localparam logic [32:0] NOP_BUB = {1'b1, 32'h0000_0013};
  logic i_clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, flush = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [11:0] cmd_imm = '0;
  logic [31:0] instr, pc;
  logic [2:0] fifo_count;
  logic bubble;
  int passed = 0, total = 0, edges = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [32:0] trace[$];

  riscv_instr_issuer #(.DEPTH(4), .HAZARD_GAP(2)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_rd(cmd_rd), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
    .i_cmd_imm(cmd_imm), .i_flush(flush), .o_instr(instr), .o_pc(pc),
    .o_fifo_count(fifo_count), .o_bubble(bubble)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [11:0] imm);
    case (op)
      2'd0: return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h03;
      2'd1: return 32'h4000_0000 | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h0B;
      2'd2: return (32'(imm) << 20) | (32'(rd) << 7) | 32'h37;
      default: return 32'h13;
    endcase
  endfunction

  function automatic int find(input logic [32:0] v);
    foreach (trace[i]) if (trace[i] === v) return i;
    return -1;
  endfunction

  function automatic logic [32:0] tr(input int i);
    return (i >= 0 && i < trace.size()) ? trace[i] : 33'h0;
  endfunction

  always @(negedge i_clk)
    if (rst_n && mon_en) begin
      check("pc", {1'b0, pc}, {1'b0, edges == 0 ? 32'd0 : 32'((edges - 1) * 4)});
      trace.push_back({bubble, instr});
      if (bubble) check("bubble_word", {1'b0, instr}, {1'b0, 32'h13});
      else if (exp_q.size() == 0) check("unexpected_issue", {32'b0, bubble}, 33'd1);
      else check("issued_word", {1'b0, instr}, {1'b0, exp_q.pop_front()});
    end

  task automatic push(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input logic [31:0] w, input bit track, output int waited);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      check("full_count", {30'b0, fifo_count}, 33'd4);
      @(negedge i_clk);
      waited++;
    end
    if (waited == 20) check("ready_timeout", {32'b0, cmd_ready}, 33'd1);
    else if (track) exp_q.push_back(w);
    @(negedge i_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input bit track = 1'b1);
    int w;
    push(op, rd, rs1, rs2, imm, enc(op, rd, rs1, rs2, imm), track, w);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check(tag, 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    int w, k;
    logic [31:0] pc0;
    repeat (2) @(negedge i_clk);
    check("rst_instr", {1'b0, instr}, {1'b0, 32'h13});
    check("rst_pc", {1'b0, pc}, 33'd0);
    check("rst_count", {30'b0, fifo_count}, 33'd0);
    check("rst_bubble", {32'b0, bubble}, 33'd1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 check("ready_after_rst", {32'b0, cmd_ready}, 33'd1);
    @(negedge i_clk);
    // Encoding with literal words, including the reserved op
    push(2'd2, 5'd1, 5'd0, 5'd0, 12'd5, 32'h005000B7, 1'b1, w);
    push(2'd0, 5'd3, 5'd1, 5'd2, 12'd0, 32'h00208183, 1'b1, w);
    push(2'd1, 5'd4, 5'd3, 5'd1, 12'd0, 32'h4011820B, 1'b1, w);
    push(2'd3, 5'd5, 5'd6, 5'd7, 12'd9, 32'h00000013, 1'b1, w);
    drain("enc_drain");
    // Hazard timing: ADD x3 then dependent SUB, then independent LI
    repeat (3) @(negedge i_clk);
    trace.delete();
    send(2'd0, 5'd3, 5'd1, 5'd2, 12'd0);
    send(2'd1, 5'd4, 5'd3, 5'd1, 12'd0);
    send(2'd2, 5'd5, 5'd0, 5'd0, 12'd7);
    drain("haz_drain");
    k = find({1'b0, enc(2'd0, 5'd3, 5'd1, 5'd2, 12'd0)});
    check("haz_found", {32'b0, k >= 0}, 33'd1);
    check("haz_nop1", tr(k + 1), NOP_BUB);
    check("haz_nop2", tr(k + 2), NOP_BUB);
    check("haz_sub", tr(k + 3), {1'b0, enc(2'd1, 5'd4, 5'd3, 5'd1, 12'd0)});
    check("haz_li", tr(k + 4), {1'b0, enc(2'd2, 5'd5, 5'd0, 5'd0, 12'd7)});
    // Backpressure: dependency chain stalls issue until the queue fills
    repeat (3) @(negedge i_clk);
    send(2'd0, 5'd10, 5'd0, 5'd0, 12'd0);
    send(2'd1, 5'd11, 5'd10, 5'd10, 12'd0);
    send(2'd0, 5'd12, 5'd11, 5'd11, 12'd0);
    send(2'd0, 5'd13, 5'd12, 5'd12, 12'd0);
    send(2'd0, 5'd14, 5'd13, 5'd13, 12'd0);
    send(2'd0, 5'd15, 5'd14, 5'd14, 12'd0);
    push(2'd2, 5'd16, 5'd0, 5'd0, 12'd9, enc(2'd2, 5'd16, 5'd0, 5'd0, 12'd9), 1'b1, w);
    check("backpressure_seen", {32'b0, w > 0}, 33'd1);
    drain("full_drain");
    check("full_count_end", {30'b0, fifo_count}, 33'd0);
    // Flush with three queued entries and a command offered during flush
    repeat (3) @(negedge i_clk);
    send(2'd0, 5'd20, 5'd0, 5'd0, 12'd0);
    send(2'd1, 5'd21, 5'd20, 5'd20, 12'd0, 1'b0);
    send(2'd0, 5'd22, 5'd21, 5'd21, 12'd0, 1'b0);
    send(2'd0, 5'd23, 5'd22, 5'd22, 12'd0, 1'b0);
    check("pre_flush_count", {30'b0, fifo_count}, 33'd3);
    pc0 = pc;
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 5'd24; cmd_imm = 12'd3;
    check("ready_in_flush", {32'b0, cmd_ready}, 33'd1);
    @(negedge i_clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_count", {30'b0, fifo_count}, 33'd0);
    check("flush_instr", {bubble, instr}, NOP_BUB);
    check("flush_pc", {1'b0, pc}, {1'b0, pc0 + 32'd4});
    repeat (4) @(negedge i_clk);
    check("flush_dropped", {30'b0, fifo_count}, 33'd0);
    // Wrap: 12 independent LIs stream without gaps
    trace.delete();
    for (int i = 1; i <= 12; i++) send(2'd2, 5'(i), 5'd0, 5'd0, 12'(i * 3));
    drain("wrap_drain");
    k = find({1'b0, enc(2'd2, 5'd1, 5'd0, 5'd0, 12'd3)});
    check("wrap_found", {32'b0, k >= 0}, 33'd1);
    for (int i = 1; i < 12; i++)
      check("wrap_order", tr(k + i), {1'b0, enc(2'd2, 5'(i + 1), 5'd0, 5'd0, 12'((i + 1) * 3))});
    // Asynchronous reset in the middle of traffic
    send(2'd2, 5'd7, 5'd0, 5'd0, 12'd1);
    send(2'd0, 5'd8, 5'd7, 5'd7, 12'd0);
    send(2'd0, 5'd9, 5'd8, 5'd8, 12'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_instr", {1'b0, instr}, {1'b0, 32'h13});
    check("mid_rst_pc", {1'b0, pc}, 33'd0);
    check("mid_rst_count", {30'b0, fifo_count}, 33'd0);
    check("mid_rst_bubble", {32'b0, bubble}, 33'd1);
    exp_q.delete();
    @(negedge i_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check("post_rst_count", {30'b0, fifo_count}, 33'd0);
    check("post_rst_ready", {32'b0, cmd_ready}, 33'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
